// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a rotating priority pointer and an optional
// hold timeout that forcibly releases an owner who keeps the resource too long.
module rr_arbiter_8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout_pulse
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  // Last hold-counter value before a forced release; unused when TIMEOUT is 0.
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [7:0] hold_cnt_q;
  logic [7:0] grant_q;
  logic [2:0] grant_idx_q;
  logic       grant_valid_q;
  logic       timeout_pulse_q;

  logic [2:0] pick_idx_d;
  logic       pick_found;
  logic       owner_release;
  logic       hold_expired;

  // Search starts at ptr_q and wraps; the 3-bit sum wraps modulo 8 by itself.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pick_idx_d = ptr_q;
    pick_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!pick_found && req[ptr_q + 3'(i)]) begin
        pick_idx_d = ptr_q + 3'(i);
        pick_found = 1'b1;
      end
    end
  end

  assign owner_release = done || !req[grant_idx_q];
  assign hold_expired  = (TIMEOUT != 0) && (hold_cnt_q == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      ptr_q           <= 3'd0;
      hold_cnt_q      <= 8'd0;
      grant_q         <= 8'h00;
      grant_idx_q     <= 3'd0;
      grant_valid_q   <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of the others.
      timeout_pulse_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_found) begin
            state_q       <= S_GRANT;
            grant_idx_q   <= pick_idx_d;
            grant_q       <= 8'b1 << pick_idx_d;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= 8'd0;
          end
        end
        S_GRANT: begin
          if (owner_release || hold_expired) begin
            state_q         <= S_IDLE;
            grant_q         <= 8'h00;
            grant_valid_q   <= 1'b0;
            ptr_q           <= grant_idx_q + 3'd1;
            hold_cnt_q      <= 8'd0;
            // A coinciding done or dropped request makes the release a normal one.
            timeout_pulse_q <= !owner_release;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant         = grant_q;
  assign grant_idx     = grant_idx_q;
  assign grant_valid   = grant_valid_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter TIMEOUT, default 16, maximum cycles a grant is held before forced release; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  request vector; bit i high = requester i wants the shared resource.
REQ-005 done  input  1  current owner releases the resource; sampled only in GRANT.
REQ-006 grant  output  8  one-hot grant, the 3-to-8 decode of grant_idx when grant_valid=1, else 8'h00.
REQ-007 grant_idx  output  3  index of current owner; holds last value when grant_valid=0.
REQ-008 grant_valid  output  1  high while a grant is active.
REQ-009 timeout_pulse  output  1  one-cycle pulse on a forced release.

Function
REQ-010 FSM has two states, IDLE and GRANT; all outputs are registered.
REQ-011 Internal 3-bit priority pointer ptr; search order ptr, ptr+1, ... ptr+7, mod 8.
REQ-012 IDLE with req != 0: the first set bit in search order becomes owner; the next edge sets grant_idx, grant_valid=1, state=GRANT (latency 1 cycle from sampled req).
REQ-013 IDLE with req == 0: state, ptr, and outputs are unchanged; grant stays 8'h00.
REQ-014 GRANT: 8-bit hold counter starts at 0 on entry and increments each cycle in GRANT.
REQ-015 GRANT release condition: done=1, or req[grant_idx]=0, or (TIMEOUT!=0 and counter==TIMEOUT-1).
REQ-016 On release: next edge sets state=IDLE, grant_valid=0, and ptr=grant_idx+1 (7 wraps to 0); counter clears.
REQ-017 Consecutive grants are separated by exactly one cycle with grant_valid=0.
REQ-018 timeout_pulse=1 for the single release cycle only when the timeout alone causes release.
REQ-019 If done or a dropped req coincides with the timeout, the release counts as normal and timeout_pulse stays 0.
REQ-020 In GRANT, changes on other req bits have no effect until the next IDLE arbitration.
REQ-021 done in IDLE is ignored.
REQ-022 grant is never multi-hot and is never nonzero when grant_valid=0.

Reset
REQ-023 rst_n=0 forces, asynchronously, state=IDLE, ptr=0, counter=0, grant=8'h00, grant_idx=0, grant_valid=0, timeout_pulse=0.
REQ-024 Reset asserted mid-GRANT drops the grant immediately, with no timeout_pulse.
REQ-025 After rst_n rises, the first arbitration uses ptr=0.

Verification
REQ-026 Reset, req=8'h01 -> one cycle later grant=8'h01, grant_idx=0, grant_valid=1; done pulse -> next cycle grant=8'h00.
REQ-027 req=8'hFF held, done pulsed once per grant -> grant_idx sequence 0,1,2,...,7,0, each grant separated by one idle cycle.
REQ-028 ptr=6 (after granting 5), req=8'h21 -> grant_idx=0 is chosen over 5, because search starts at 6 and wraps.
REQ-029 TIMEOUT=16, req=8'h08 held, done=0 -> grant_valid high exactly 16 cycles, timeout_pulse=1 on the release cycle, then re-grant to 3 after one idle cycle.
REQ-030 done=1 on the same cycle as counter==15 -> release with timeout_pulse=0.
REQ-031 rst_n pulled low while grant=8'h10 -> grant=8'h00 immediately; after release, req=8'h30 -> grant_idx=4 (ptr reset to 0).
